norm_shift_ctrl: RTL and testbench
==================================

NORM_SHIFT_CTRL -- requirements
Module: norm_shift_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, operand width.
REQ-002 The block SHALL have parameter OUT_W, default 8, normalized result width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed below.
REQ-004 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, operand offered.
REQ-007 The block SHALL have port in_ready, output, 1, operand accepted when in_valid && in_ready at a clock edge.
REQ-008 The block SHALL have port data_in, input, DATA_W, operand.
REQ-009 The block SHALL have port sh_ld, output, 1, load strobe to the downstream right_shifter.
REQ-010 The block SHALL have port sh_shift_enable, output, 1, one-bit right-shift strobe to the right_shifter.
REQ-011 The block SHALL have port sh_in, output, DATA_W, right_shifter load data (registered operand).
REQ-012 The block SHALL have port sh_out, input, DATA_W, right_shifter current contents.
REQ-013 The block SHALL have port out_valid, output, 1, result available.
REQ-014 The block SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready at a clock edge.
REQ-015 The block SHALL have port result, output, OUT_W, normalized value.
REQ-016 The block SHALL have port shift_count, output, 4, number of shifts applied (0..DATA_W-OUT_W).

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE; in_ready is high only in IDLE.
REQ-018 On accept in IDLE, the block SHALL register data_in into sh_in, clear the count and sticky bit, and go to LOAD.
REQ-019 In LOAD, sh_ld SHALL be 1 for exactly one cycle; the next state is SHIFT.
REQ-020 In SHIFT, sh_shift_enable SHALL equal OR of sh_out[DATA_W-1:OUT_W]; when 1, the count increments and the sticky bit takes sh_out[0] at the same edge.
REQ-021 In SHIFT with upper bits zero, result SHALL capture sh_out[OUT_W-1:0] (see REQ-030), and the state moves to DONE.
REQ-022 Latency from the accept edge to out_valid high SHALL be exactly 2+N cycles, where N = required shifts; throughput is one shift per cycle.
REQ-023 In DONE, out_valid SHALL be 1, with result and shift_count held stable until out_ready; on handshake the state returns to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; sh_ld and sh_shift_enable SHALL never be high in the same cycle.
REQ-025 Operand zero SHALL produce N=0, result 0, latency 2.

Reset
REQ-026 With rst low, the block SHALL go to IDLE immediately and asynchronously, regardless of state, including mid-SHIFT.
REQ-027 During reset, in_ready=0, out_valid=0, sh_ld=0, sh_shift_enable=0, and sh_in, result, shift_count and sticky are all 0; in_ready goes to 1 in the first cycle after release.

Configuration
REQ-028 Macro NORM_ROUND_EN SHALL select round-half-up at capture.
REQ-029 Without NORM_ROUND_EN, result SHALL equal sh_out[OUT_W-1:0] (truncation).
REQ-030 With NORM_ROUND_EN and N>0, result SHALL equal sh_out[OUT_W-1:0] + sticky, saturating at all-ones; latency is unchanged.

Structure
REQ-031 Package norm_pkg SHALL hold the FSM state enum (2 bits), DATA_W/OUT_W defaults, and CNT_W=4.
REQ-032 The shift counter SHALL be one sub-module norm_shift_counter (clear, enable, 4-bit, async active-low reset); the right_shifter is external and not instantiated.

Verification
REQ-033 The bench SHALL check: data_in 0x00FF -> shift_count 0, result 0xFF, out_valid 2 cycles after accept.
REQ-034 The bench SHALL check: data_in 0xBBAA -> 8 sh_shift_enable pulses, result 0xBB (truncated) or 0xBC (NORM_ROUND_EN), shift_count 8, latency 10.
REQ-035 The bench SHALL check: data_in 0xFFFF with NORM_ROUND_EN -> result 0xFF (saturated), shift_count 8.
REQ-036 The bench SHALL check: 0x0100 accepted, out_ready held low 5 cycles -> result 0x80, count 1 stable throughout, in_ready 0 until handshake, a second in_valid ignored.
REQ-037 The bench SHALL check: rst low at the 3rd shift of 0xF0F0 -> outputs at reset values immediately; a new 0x0003 then completes with result 0x03, count 0.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared definitions for the normalising shift controller: FSM states,
// default operand/result widths and the shift-counter width.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int OUT_W_DEF  = 8;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/norm_shift_ctrl_if.sv
// Bundle of operand/result handshakes and right_shifter strobes.
// slave = the controller, master = its environment (source, sink, shifter).
interface norm_shift_ctrl_if
    import norm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              sh_ld;
    logic              sh_shift_enable;
    logic [DATA_W-1:0] sh_in;
    logic [DATA_W-1:0] sh_out;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  result;
    logic [CNT_W-1:0]  shift_count;

    modport master (
        output in_valid, data_in, out_ready, sh_out,
        input  in_ready, sh_ld, sh_shift_enable, sh_in, out_valid, result, shift_count
    );

    modport slave (
        input  in_valid, data_in, out_ready, sh_out,
        output in_ready, sh_ld, sh_shift_enable, sh_in, out_valid, result, shift_count
    );

endinterface

// File: rtl/norm_shift_counter.sv
// Shift counter with synchronous clear (priority) and increment enable.
module norm_shift_counter
    import norm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalising controller: right-shifts an operand through an external shifter
// until it fits OUT_W bits. Define NORM_ROUND_EN for round-half-up at capture.
module norm_shift_ctrl
    import norm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    norm_shift_ctrl_if.slave  bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_in_q, sh_in_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic              sticky_q, sticky_d;
    logic              in_ready_q, in_ready_d;
    logic              cnt_clear;
    logic              cnt_en;
    logic              upper_nz;
    logic [OUT_W-1:0]  low_bits;
    logic [OUT_W-1:0]  rounded;
    logic [CNT_W-1:0]  count;

    assign upper_nz = |bus.sh_out[DATA_W-1:OUT_W];
    assign low_bits = bus.sh_out[OUT_W-1:0];

`ifdef NORM_ROUND_EN
    // sticky holds the last bit shifted out, i.e. the half-LSB weight
    always_comb begin
        rounded = low_bits;
        if (sticky_q && (count != '0) && !(&low_bits)) begin
            rounded = low_bits + OUT_W'(1);
        end
    end
`else
    assign rounded = low_bits;
`endif

    always_comb begin
        state_d   = state_q;
        sh_in_d   = sh_in_q;
        result_d  = result_q;
        sticky_d  = sticky_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sh_in_d   = bus.data_in;
                    sticky_d  = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                if (upper_nz) begin
                    cnt_en   = 1'b1;
                    sticky_d = bus.sh_out[0];
                end else begin
                    result_d = rounded;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // registered so in_ready stays low through reset and the release cycle
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sh_in_q    <= '0;
            result_q   <= '0;
            sticky_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_in_q    <= sh_in_d;
            result_q   <= result_d;
            sticky_q   <= sticky_d;
            in_ready_q <= in_ready_d;
        end
    end

    norm_shift_counter u_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (count)
    );

    assign bus.in_ready        = in_ready_q;
    assign bus.sh_ld           = (state_q == LOAD);
    assign bus.sh_shift_enable = (state_q == SHIFT) && upper_nz;
    assign bus.sh_in           = sh_in_q;
    assign bus.out_valid       = (state_q == DONE);
    assign bus.result          = result_q;
    assign bus.shift_count     = count;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl with a behavioural right_shifter;
// expectations come from a reference model pushed to a scoreboard queue.
module tb_norm_shift_ctrl;
    import norm_pkg::*;

    localparam int DW = 16;
    localparam int OW = 8;

    typedef struct {
        logic [OW-1:0]    res;
        logic [CNT_W-1:0] cnt;
        int               lat;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    int      checks = 0;
    int      errors = 0;
    exp_t    sb[$];
    logic [DW-1:0] shreg;

    norm_shift_ctrl_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

    norm_shift_ctrl #(.DATA_W(DW), .OUT_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // external right_shifter
    always @(posedge clk or negedge rst) begin
        if (!rst)                     shreg <= '0;
        else if (bus.sh_ld)           shreg <= bus.sh_in;
        else if (bus.sh_shift_enable) shreg <= shreg >> 1;
    end
    assign bus.sh_out = shreg;

    function automatic exp_t model(input logic [DW-1:0] d);
        exp_t          e;
        logic [DW-1:0] v;
        int            n;
        logic          st;
        v  = d;
        n  = 0;
        st = 1'b0;
        while (v[DW-1:OW] != '0) begin
            st = v[0];
            v  = v >> 1;
            n++;
        end
        e.res = v[OW-1:0];
`ifdef NORM_ROUND_EN
        if (n > 0 && st && e.res != 8'hFF) e.res = e.res + 8'd1;
`endif
        e.cnt = CNT_W'(n);
        e.lat = 2 + n;
        return e;
    endfunction

    task automatic run_txn(input logic [DW-1:0] d, input int hold, input bit spam,
                           input string name,
                           output logic [OW-1:0] r, output logic [CNT_W-1:0] c);
        exp_t e;
        int   k, lat, pulses, lds;
        r = '0;
        c = '0;
        @(negedge clk);
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL %s in_ready_timeout got=%0b want=1", name, bus.in_ready);
            return;
        end
        bus.data_in  = d;
        bus.in_valid = 1'b1;
        sb.push_back(model(d));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        lat    = 0;
        pulses = 0;
        lds    = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.sh_shift_enable) pulses++;
            if (bus.sh_ld) lds++;
            checks++;
            if (bus.sh_ld && bus.sh_shift_enable) begin
                errors++;
                $display("FAIL %s ld_shift_overlap got=11 want=not_both", name);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        r = bus.result;
        c = bus.shift_count;
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d", name, lat, e.lat);
        end
        checks++;
        if (bus.result !== e.res) begin
            errors++;
            $display("FAIL %s result got=%h want=%h", name, bus.result, e.res);
        end
        checks++;
        if (bus.shift_count !== e.cnt) begin
            errors++;
            $display("FAIL %s shift_count got=%0d want=%0d", name, bus.shift_count, e.cnt);
        end
        checks++;
        if (pulses !== int'(e.cnt)) begin
            errors++;
            $display("FAIL %s shift_pulses got=%0d want=%0d", name, pulses, e.cnt);
        end
        checks++;
        if (lds !== 1) begin
            errors++;
            $display("FAIL %s ld_pulses got=%0d want=1", name, lds);
        end
        if (spam) begin
            bus.data_in  = 16'h1234;
            bus.in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.result !== r || bus.shift_count !== c) begin
                errors++;
                $display("FAIL %s hold%0d got=v%0b/r%0b/%h/%0d want=v1/r0/%h/%0d",
                         name, i, bus.out_valid, bus.in_ready, bus.result,
                         bus.shift_count, r, c);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sh_in !== d) begin
            errors++;
            $display("FAIL %s handshake got=v%0b/r%0b/sh_in=%h want=v0/r1/sh_in=%h",
                     name, bus.out_valid, bus.in_ready, bus.sh_in, d);
        end
        $display("txn %s data=%h result=%h count=%0d latency=%0d", name, d, r, c, lat);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.sh_ld !== 1'b0 ||
            bus.sh_shift_enable !== 1'b0 || bus.sh_in !== '0 || bus.result !== '0 ||
            bus.shift_count !== '0 || dut.sticky_q !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_values got=r%0b v%0b ld%0b se%0b in=%h res=%h cnt=%0d st=%0b want=all_zero",
                     name, bus.in_ready, bus.out_valid, bus.sh_ld, bus.sh_shift_enable,
                     bus.sh_in, bus.result, bus.shift_count, dut.sticky_q);
        end
    endtask

    task automatic release_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_at_release got=%0b want=0", name, bus.in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after_release got=%0b want=1", name, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        release_reset("reset");
        $display("txn reset released");
    endtask

    task automatic test_no_shift();
        logic [OW-1:0] r;
        logic [CNT_W-1:0] c;
        run_txn(16'h00FF, 0, 1'b0, "no_shift", r, c);
        checks++;
        if (r !== 8'hFF || c !== 4'd0) begin
            errors++;
            $display("FAIL no_shift const got=%h/%0d want=ff/0", r, c);
        end
        run_txn(16'h0000, 0, 1'b0, "zero", r, c);
        checks++;
        if (r !== 8'h00 || c !== 4'd0) begin
            errors++;
            $display("FAIL zero const got=%h/%0d want=00/0", r, c);
        end
    endtask

    task automatic test_full_shift();
        logic [OW-1:0] r;
        logic [CNT_W-1:0] c;
        logic [OW-1:0] want;
`ifdef NORM_ROUND_EN
        want = 8'hBC;
`else
        want = 8'hBB;
`endif
        run_txn(16'hBBAA, 1, 1'b0, "bbaa", r, c);
        checks++;
        if (r !== want || c !== 4'd8) begin
            errors++;
            $display("FAIL bbaa const got=%h/%0d want=%h/8", r, c, want);
        end
        run_txn(16'hFFFF, 0, 1'b0, "ffff_sat", r, c);
        checks++;
        if (r !== 8'hFF || c !== 4'd8) begin
            errors++;
            $display("FAIL ffff_sat const got=%h/%0d want=ff/8", r, c);
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] r;
        logic [CNT_W-1:0] c;
        run_txn(16'h0100, 5, 1'b1, "backpressure", r, c);
        checks++;
        if (r !== 8'h80 || c !== 4'd1) begin
            errors++;
            $display("FAIL backpressure const got=%h/%0d want=80/1", r, c);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.sh_ld !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL backpressure ignored_valid got=ld%0b/v%0b want=0/0",
                         bus.sh_ld, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [OW-1:0] r;
        logic [CNT_W-1:0] c;
        int k, pulses;
        @(negedge clk);
        bus.data_in  = 16'hF0F0;
        bus.in_valid = 1'b1;
        sb.push_back(model(16'hF0F0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        k      = 0;
        pulses = 0;
        while (k < 50) begin
            if (bus.sh_shift_enable) begin
                pulses++;
                if (pulses == 3) break;
            end
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL mid_shift reach_third got=%0d want=3", pulses);
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("mid_shift");
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        check_reset_values("mid_shift_held");
        release_reset("mid_shift");
        $display("txn mid_shift reset after %0d shifts", pulses);
        run_txn(16'h0003, 0, 1'b0, "after_reset", r, c);
        checks++;
        if (r !== 8'h03 || c !== 4'd0) begin
            errors++;
            $display("FAIL after_reset const got=%h/%0d want=03/0", r, c);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] r;
        logic [CNT_W-1:0] c;
        for (int i = 0; i < 8; i++) begin
            run_txn(DW'($urandom), i % 3, 1'b0, "random", r, c);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_no_shift();
        test_full_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
